// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters and EX-stage
// branch resolution (direction decode, mispredict detect, training, stats).
module branch_predictor #(
  parameter int INDEX_W = 6
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_if_pc,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_pc,
  input  logic        i_ex_valid,
  input  logic        i_ex_is_br,
  input  logic        i_ex_is_jmp,
  input  logic [2:0]  i_ex_funct3,
  input  logic [31:0] i_ex_pc,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  input  logic [31:0] i_ex_pred_pc,
  output logic        o_br_un,
  input  logic        i_br_less,
  input  logic        i_br_equal,
  output logic        o_ex_taken,
  output logic        o_mispredict,
  output logic [31:0] o_redirect_pc,
  output logic [31:0] o_br_cnt,
  output logic [31:0] o_mispred_cnt
);
  localparam int DEPTH = 1 << INDEX_W;
  localparam int TAG_W = 32 - INDEX_W - 2;

  logic [DEPTH-1:0]            valid_q;
  logic [DEPTH-1:0][TAG_W-1:0] tag_q;
  logic [DEPTH-1:0][31:0]      target_q;
  logic [DEPTH-1:0][1:0]       ctr_q;

  // The carried prediction bit is redundant with the carried PC.
  logic unused_pred_taken;
  assign unused_pred_taken = i_ex_pred_taken;

  // IF lookup
  logic [INDEX_W-1:0] if_idx;
  logic               if_hit;
  assign if_idx       = i_if_pc[INDEX_W+1:2];
  assign if_hit       = valid_q[if_idx] && (tag_q[if_idx] == i_if_pc[31:INDEX_W+2]);
  assign o_pred_taken = if_hit && ctr_q[if_idx][1];
  assign o_pred_pc    = o_pred_taken ? target_q[if_idx] : i_if_pc + 32'd4;

  // EX resolution
  logic [INDEX_W-1:0] ex_idx;
  logic [TAG_W-1:0]   ex_tag;
  logic               ex_hit, dir, legal, ctrl;
  logic [31:0]        actual_pc;

  assign ex_idx = i_ex_pc[INDEX_W+1:2];
  assign ex_tag = i_ex_pc[31:INDEX_W+2];
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign legal  = (i_ex_funct3[2:1] != 2'b01);

  always_comb begin
    dir = 1'b0;
    case (i_ex_funct3)
      3'b000:         dir = i_br_equal;
      3'b001:         dir = !i_br_equal;
      3'b100, 3'b110: dir = i_br_less;
      3'b101, 3'b111: dir = !i_br_less;
      default:        dir = 1'b0;
    endcase
  end

  assign o_br_un       = i_ex_funct3[1];
  assign ctrl          = i_ex_valid && (i_ex_is_br || i_ex_is_jmp);
  assign o_ex_taken    = i_ex_valid && (i_ex_is_jmp || (i_ex_is_br && dir));
  assign actual_pc     = o_ex_taken ? i_ex_target : i_ex_pc + 32'd4;
  assign o_redirect_pc = actual_pc;
  assign o_mispredict  = ctrl && (i_ex_pred_pc != actual_pc);

  // Training; jumps take priority if both type flags are set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q  <= '0;
      tag_q    <= '0;
      target_q <= '0;
      ctr_q    <= '0;
    end else if (i_ex_valid && i_ex_is_jmp) begin
      valid_q[ex_idx]  <= 1'b1;
      tag_q[ex_idx]    <= ex_tag;
      target_q[ex_idx] <= i_ex_target;
      ctr_q[ex_idx]    <= 2'b11;
    end else if (i_ex_valid && i_ex_is_br && legal) begin
      if (ex_hit) begin
        if (o_ex_taken) begin
          target_q[ex_idx] <= i_ex_target;
          if (ctr_q[ex_idx] != 2'b11) ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
        end else if (ctr_q[ex_idx] != 2'b00) begin
          ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
        end
      end else if (o_ex_taken) begin
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= i_ex_target;
        ctr_q[ex_idx]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_br_cnt      <= '0;
      o_mispred_cnt <= '0;
    end else begin
      if (ctrl)         o_br_cnt      <= o_br_cnt + 32'd1;
      if (o_mispredict) o_mispred_cnt <= o_mispred_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed scenarios plus randomized traffic checked
// against an entry-level behavioural model of the predictor.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        ex_valid, ex_is_br, ex_is_jmp;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc, ex_target, ex_pred_pc;
  logic        ex_pred_taken;
  logic        br_un, br_less, br_equal;
  logic        ex_taken, mispredict;
  logic [31:0] redirect_pc, br_cnt, mispred_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_predictor #(.INDEX_W(6)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_if_pc(if_pc),
    .o_pred_taken(pred_taken), .o_pred_pc(pred_pc),
    .i_ex_valid(ex_valid), .i_ex_is_br(ex_is_br), .i_ex_is_jmp(ex_is_jmp),
    .i_ex_funct3(ex_funct3), .i_ex_pc(ex_pc), .i_ex_target(ex_target),
    .i_ex_pred_taken(ex_pred_taken), .i_ex_pred_pc(ex_pred_pc),
    .o_br_un(br_un), .i_br_less(br_less), .i_br_equal(br_equal),
    .o_ex_taken(ex_taken), .o_mispredict(mispredict), .o_redirect_pc(redirect_pc),
    .o_br_cnt(br_cnt), .o_mispred_cnt(mispred_cnt)
  );

  // Reference model: one record per table slot, counter kept as an integer 0..3
  typedef struct {
    bit          v;
    logic [31:0] tag;
    logic [31:0] tgt;
    int          ctr;
  } ent_t;
  ent_t        m[64];
  logic [31:0] m_br, m_mis;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m[slot(pc)].v && (m[slot(pc)].tag == (pc >> 8));
  endfunction

  function automatic logic [31:0] m_pred_pc(input logic [31:0] pc);
    if (m_hit(pc) && m[slot(pc)].ctr >= 2) return m[slot(pc)].tgt;
    return pc + 32'd4;
  endfunction

  function automatic bit m_pred_taken(input logic [31:0] pc);
    return m_hit(pc) && m[slot(pc)].ctr >= 2;
  endfunction

  function automatic bit m_taken();
    bit d;
    case (ex_funct3)
      3'd0: d = br_equal;
      3'd1: d = !br_equal;
      3'd4, 3'd6: d = br_less;
      3'd5, 3'd7: d = !br_less;
      default: d = 0;
    endcase
    return ex_valid && (ex_is_jmp || (ex_is_br && d));
  endfunction

  function automatic logic [31:0] m_next();
    return m_taken() ? ex_target : ex_pc + 32'd4;
  endfunction

  function automatic bit m_mispred();
    return ex_valid && (ex_is_br || ex_is_jmp) && (ex_pred_pc != m_next());
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m[i] = '{0, 32'd0, 32'd0, 0};
    m_br = 0;
    m_mis = 0;
  endtask

  task automatic model_commit();
    int s;
    bit tk;
    s  = slot(ex_pc);
    tk = m_taken();
    if (ex_valid && (ex_is_br || ex_is_jmp)) m_br = m_br + 1;
    if (m_mispred()) m_mis = m_mis + 1;
    if (!ex_valid) return;
    if (ex_is_jmp) m[s] = '{1, ex_pc >> 8, ex_target, 3};
    else if (ex_is_br && ex_funct3 != 3'd2 && ex_funct3 != 3'd3) begin
      if (m_hit(ex_pc)) begin
        if (tk) begin
          m[s].tgt = ex_target;
          m[s].ctr = (m[s].ctr == 3) ? 3 : m[s].ctr + 1;
        end else m[s].ctr = (m[s].ctr == 0) ? 0 : m[s].ctr - 1;
      end else if (tk) m[s] = '{1, ex_pc >> 8, ex_target, 2};
    end
  endtask

  // Advance one clock; the model trains on the same inputs the DUT sees at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_commit();
    @(negedge clk);
  endtask

  task automatic drive_ex(input bit v, input bit br, input bit jmp, input logic [2:0] f3,
                          input logic [31:0] pc, input logic [31:0] tgt,
                          input logic [31:0] ppc, input bit less, input bit eq);
    ex_valid = v; ex_is_br = br; ex_is_jmp = jmp; ex_funct3 = f3;
    ex_pc = pc; ex_target = tgt; ex_pred_pc = ppc; ex_pred_taken = (ppc != pc + 32'd4);
    br_less = less; br_equal = eq;
  endtask

  task automatic idle_ex();
    drive_ex(0, 0, 0, 3'd0, 32'd0, 32'd0, 32'd0, 0, 0);
  endtask

  task automatic test_reset();
    idle_ex();
    if_pc = 32'h100;
    rst_n = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    #1;
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL reset_pred_taken got=%0b exp=0", pred_taken); end
    checks++; if (pred_pc !== 32'h104) begin failures++; $display("FAIL reset_pred_pc got=%h exp=00000104", pred_pc); end
    checks++; if (br_cnt !== 32'd0) begin failures++; $display("FAIL reset_br_cnt got=%0d exp=0", br_cnt); end
    checks++; if (mispred_cnt !== 32'd0) begin failures++; $display("FAIL reset_mispred_cnt got=%0d exp=0", mispred_cnt); end
    @(negedge clk);
    rst_n = 1;
    if_pc = 32'hFFFF_FFFC;
    #1;
    checks++; if (pred_pc !== 32'h0) begin failures++; $display("FAIL wrap_pred_pc got=%h exp=00000000", pred_pc); end
  endtask

  task automatic test_alloc_saturate();
    if_pc = 32'h100;
    drive_ex(1, 1, 0, 3'b100, 32'h100, 32'h80, 32'h104, 1, 0);
    #1;
    checks++; if (mispredict !== 1'b1 || redirect_pc !== 32'h80 || ex_taken !== 1'b1)
      begin failures++; $display("FAIL alloc_resolve got mis=%0b red=%h tk=%0b exp mis=1 red=00000080 tk=1", mispredict, redirect_pc, ex_taken); end
    checks++; if (pred_pc !== 32'h104) begin failures++; $display("FAIL same_cycle_lookup got=%h exp=00000104", pred_pc); end
    checks++; if (br_un !== 1'b0) begin failures++; $display("FAIL br_un_blt got=%0b exp=0", br_un); end
    tick();
    ex_pred_pc = 32'h80;
    #1;
    checks++; if (pred_pc !== 32'h80 || pred_taken !== 1'b1) begin failures++; $display("FAIL alloc_lookup got=%h/%0b exp=00000080/1", pred_pc, pred_taken); end
    checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL correct_pred got=%0b exp=0", mispredict); end
    tick();
    tick();
    #1;
    checks++; if (br_cnt !== 32'd3 || mispred_cnt !== 32'd1) begin failures++; $display("FAIL alloc_counts got=%0d/%0d exp=3/1", br_cnt, mispred_cnt); end
  endtask

  task automatic test_hysteresis();
    drive_ex(1, 1, 0, 3'b001, 32'h100, 32'h80, 32'h80, 0, 1);
    #1;
    checks++; if (mispredict !== 1'b1 || redirect_pc !== 32'h104 || ex_taken !== 1'b0)
      begin failures++; $display("FAIL hyst_resolve got mis=%0b red=%h tk=%0b exp mis=1 red=00000104 tk=0", mispredict, redirect_pc, ex_taken); end
    tick();
    #1;
    checks++; if (pred_pc !== 32'h80) begin failures++; $display("FAIL hyst_still_taken got=%h exp=00000080", pred_pc); end
    tick();
    #1;
    checks++; if (pred_pc !== 32'h104 || pred_taken !== 1'b0) begin failures++; $display("FAIL hyst_flipped got=%h/%0b exp=00000104/0", pred_pc, pred_taken); end
  endtask

  task automatic test_unsigned_illegal();
    drive_ex(0, 1, 0, 3'b110, 32'h100, 32'h80, 32'h104, 1, 0);
    #1;
    checks++; if (br_un !== 1'b1) begin failures++; $display("FAIL br_un_bltu got=%0b exp=1", br_un); end
    checks++; if (mispredict !== 1'b0 || ex_taken !== 1'b0) begin failures++; $display("FAIL bubble_quiet got mis=%0b tk=%0b exp 0/0", mispredict, ex_taken); end
    // Entry at 0x100 sits at ctr 01; a decrement here would hide the later re-taken prediction.
    drive_ex(1, 1, 0, 3'b011, 32'h100, 32'h80, 32'h104, 1, 1);
    #1;
    checks++; if (ex_taken !== 1'b0 || mispredict !== 1'b0) begin failures++; $display("FAIL illegal_resolve got tk=%0b mis=%0b exp 0/0", ex_taken, mispredict); end
    tick();
    drive_ex(1, 1, 0, 3'b100, 32'h100, 32'h80, 32'h104, 1, 0);
    tick();
    idle_ex();
    #1;
    checks++; if (pred_pc !== 32'h80) begin failures++; $display("FAIL illegal_no_update got=%h exp=00000080", pred_pc); end
  endtask

  task automatic test_jump_alias();
    drive_ex(1, 0, 1, 3'b000, 32'h100, 32'h400, 32'h80, 0, 0);
    #1;
    checks++; if (mispredict !== 1'b1 || redirect_pc !== 32'h400) begin failures++; $display("FAIL jal_resolve got mis=%0b red=%h exp 1/00000400", mispredict, redirect_pc); end
    tick();
    idle_ex();
    #1;
    checks++; if (pred_pc !== 32'h400) begin failures++; $display("FAIL jal_lookup got=%h exp=00000400", pred_pc); end
    drive_ex(1, 1, 0, 3'b000, 32'h200, 32'h600, 32'h204, 0, 1);
    tick();
    idle_ex();
    #1;
    checks++; if (pred_pc !== 32'h104 || pred_taken !== 1'b0) begin failures++; $display("FAIL alias_miss got=%h/%0b exp=00000104/0", pred_pc, pred_taken); end
    if_pc = 32'h200;
    #1;
    checks++; if (pred_pc !== 32'h600) begin failures++; $display("FAIL alias_new got=%h exp=00000600", pred_pc); end
  endtask

  task automatic test_async_reset();
    if_pc = 32'h500;
    drive_ex(1, 1, 0, 3'b100, 32'h500, 32'h900, 32'h504, 1, 0);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    checks++; if (pred_pc !== 32'h504 || br_cnt !== 32'd0 || mispred_cnt !== 32'd0)
      begin failures++; $display("FAIL async_clear got=%h cnt=%0d/%0d exp=00000504 0/0", pred_pc, br_cnt, mispred_cnt); end
    if_pc = 32'h200;
    #1;
    checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL async_clear_old got=%0b exp=0", pred_taken); end
    tick();
    rst_n = 1;
    drive_ex(0, 1, 0, 3'b100, 32'h500, 32'h900, 32'h504, 1, 0);
    if_pc = 32'h500;
    #1;
    checks++; if (mispredict !== 1'b0) begin failures++; $display("FAIL bubble_mispred got=%0b exp=0", mispredict); end
    tick();
    #1;
    checks++; if (pred_taken !== 1'b0 || br_cnt !== 32'd0) begin failures++; $display("FAIL no_alloc got=%0b cnt=%0d exp 0/0", pred_taken, br_cnt); end
    // First live edge after release must train.
    ex_valid = 1;
    tick();
    #1;
    checks++; if (pred_pc !== 32'h900 || br_cnt !== 32'd1) begin failures++; $display("FAIL first_edge got=%h cnt=%0d exp=00000900 1", pred_pc, br_cnt); end
  endtask

  function automatic logic [31:0] rand_pc();
    case ($urandom_range(0, 5))
      0: return 32'h100;
      1: return 32'h200;
      2: return 32'h104;
      3: return 32'hFFFF_FFFC;
      4: return 32'h300;
      default: return {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] pc, ppc;
    int kind;
    for (int n = 0; n < 400; n++) begin
      pc   = rand_pc();
      ppc  = ($urandom_range(0, 3) != 0) ? m_pred_pc(pc) : {$urandom, 2'b00} >> 2 << 2;
      kind = $urandom_range(0, 9);
      drive_ex(kind != 0, kind >= 3, kind == 1 || kind == 2, 3'($urandom_range(0, 7)), pc,
               rand_pc(), ppc, 1'($urandom), 1'($urandom));
      if_pc = rand_pc();
      #1;
      checks++; if (pred_taken !== m_pred_taken(if_pc) || pred_pc !== m_pred_pc(if_pc))
        begin failures++; $display("FAIL rnd_pred n=%0d pc=%h got=%0b/%h exp=%0b/%h", n, if_pc, pred_taken, pred_pc, m_pred_taken(if_pc), m_pred_pc(if_pc)); end
      checks++; if (ex_taken !== m_taken() || mispredict !== m_mispred() || redirect_pc !== m_next() || br_un !== ex_funct3[1])
        begin failures++; $display("FAIL rnd_ex n=%0d got tk=%0b mis=%0b red=%h exp tk=%0b mis=%0b red=%h", n, ex_taken, mispredict, redirect_pc, m_taken(), m_mispred(), m_next()); end
      checks++; if (br_cnt !== m_br || mispred_cnt !== m_mis)
        begin failures++; $display("FAIL rnd_cnt n=%0d got=%0d/%0d exp=%0d/%0d", n, br_cnt, mispred_cnt, m_br, m_mis); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_alloc_saturate();
    test_hysteresis();
    test_unsigned_illegal();
    test_jump_alias();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
